// File: rtl/cpu_pkg.sv
// Shared RV32I CPU definitions: reset/NOP constants, base opcodes used by
// fetch, decode and hazard logic, and the fetch-stage FSM state encoding.
package cpu_pkg;

   localparam logic [31:0] CPU_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] CPU_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc} holding buffer for a fetch response that arrives
// while decode is stalled. Clear has priority over load.
module fetch_skid_buffer
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        clear,
   input  logic [31:0] load_instr,
   input  logic [31:0] load_pc,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic        full
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full  <= 1'b0;
         instr <= '0;
         pc    <= '0;
      end else if (clear) begin
         full <= 1'b0;
      end else if (load) begin
         full  <= 1'b1;
         instr <= load_instr;
         pc    <= load_pc;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage with IF/ID register and one-entry skid buffer.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_stall_cycles counters.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = CPU_RESET_PC,
   parameter logic [31:0] NOP_INSTR = CPU_NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic        id_valid
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall_cycles
`endif
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic         inflight;
   logic [31:0]  inflight_pc;
   logic [31:0]  redirect_target;

   logic         skid_load;
   logic         skid_clear;
   logic         skid_full;
   logic [31:0]  skid_instr;
   logic [31:0]  skid_pc;

   logic         id_load;
   logic         id_next_valid;
   logic [31:0]  id_next_instr;
   logic [31:0]  id_next_pc;

   assign redirect_target = redirect_pc & ~32'h3;
   assign imem_addr       = pc;

   fetch_skid_buffer u_skid (
      .clk        (clk),
      .rst        (rst),
      .load       (skid_load),
      .clear      (skid_clear),
      .load_instr (imem_rdata),
      .load_pc    (inflight_pc),
      .instr      (skid_instr),
      .pc         (skid_pc),
      .full       (skid_full)
   );

   // Redirect overrides stall and drops whatever response is arriving.
   always_comb begin
      imem_req      = 1'b0;
      skid_load     = 1'b0;
      skid_clear    = 1'b0;
      id_load       = 1'b0;
      id_next_valid = 1'b0;
      id_next_instr = NOP_INSTR;
      id_next_pc    = id_pc;
      if (redirect_valid) begin
         skid_clear = 1'b1;
         id_load    = 1'b1;
      end else begin
         case (state)
            RUN: begin
               imem_req  = !stall;
               skid_load = inflight && stall;
               id_load   = !stall;
               if (inflight) begin
                  id_next_valid = 1'b1;
                  id_next_instr = imem_rdata;
                  id_next_pc    = inflight_pc;
               end
            end
            HOLD: begin
               imem_req      = !stall;
               skid_clear    = !stall;
               id_load       = !stall;
               id_next_valid = skid_full;
               id_next_instr = skid_instr;
               id_next_pc    = skid_pc;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         id_valid    <= 1'b0;
         id_instr    <= NOP_INSTR;
         id_pc       <= '0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            inflight_pc <= pc;
            pc          <= pc + 32'd4;
         end
         if (id_load) begin
            id_valid <= id_next_valid;
            id_instr <= id_next_instr;
            id_pc    <= id_next_pc;
         end
         if (redirect_valid) begin
            pc    <= redirect_target;
            state <= RUN;
         end else begin
            case (state)
               IDLE: state <= RUN;
               RUN:  if (inflight && stall) state <= HOLD;
               HOLD: if (!stall) state <= RUN;
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched      <= '0;
         perf_stall_cycles <= '0;
      end else begin
         if (id_load && id_next_valid) perf_fetched <= perf_fetched + 32'd1;
         if (stall && id_valid) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming fetch, stall/skid, redirects,
// PC wrap and mid-HOLD reset. Counter checks are included with FETCH_PERF_CNT_EN.
module tb_fetch_stage;
   import cpu_pkg::*;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        id_valid;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall_cycles;
`endif

   int checks = 0;
   int fails  = 0;

   fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .id_valid       (id_valid)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched      (perf_fetched),
      .perf_stall_cycles (perf_stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A00_0000;
   endfunction

   // Synchronous instruction memory: data one cycle after the request.
   always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b expected 0", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
      checks++; if ({id_valid, id_instr, id_pc} !== {1'b0, NOP, 32'h0}) begin
         fails++; $display("FAIL reset_ifid: got %b/%h/%h expected 0/%h/0", id_valid, id_instr, id_pc, NOP);
      end
`ifdef FETCH_PERF_CNT_EN
      checks++; if ({perf_fetched, perf_stall_cycles} !== 64'h0) begin
         fails++; $display("FAIL reset_perf: got %h/%h expected 0/0", perf_fetched, perf_stall_cycles);
      end
`endif
   endtask

   task automatic test_basic_fetch;
      logic [31:0] a;
      @(negedge clk); rst = 1'b0; #1;
      checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL idle_req: got %b expected 0", imem_req); end
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk); #1;
         a = 4 * (i - 1);
         checks++; if ({imem_req, imem_addr} !== {1'b1, a}) begin
            fails++; $display("FAIL basic_addr c%0d: got %b/%h expected 1/%h", i, imem_req, imem_addr, a);
         end
         a = (i >= 3) ? 4 * (i - 3) : 0;
         checks++; if ({id_valid, id_instr, id_pc} !== ((i >= 3) ? {1'b1, mem_word(a), a} : {1'b0, NOP, 32'h0})) begin
            fails++; $display("FAIL basic_ifid c%0d: got %b/%h/%h expected pc %h valid %0d", i, id_valid, id_instr, id_pc, a, i >= 3);
         end
      end
   endtask

   task automatic test_stall;
      logic [31:0] ea, ep;
      for (int j = 0; j < 7; j++) begin
         @(negedge clk); stall = (j < 3); #1;
         ea = (j <= 3) ? 32'h14 : 32'h14 + 4 * (j - 3);
         ep = (j <= 3) ? 32'h0C : 32'h0C + 4 * (j - 3);
         checks++; if ({imem_req, imem_addr} !== {(j >= 3), ea}) begin
            fails++; $display("FAIL stall_req j%0d: got %b/%h expected %0d/%h", j, imem_req, imem_addr, j >= 3, ea);
         end
         checks++; if ({id_valid, id_instr, id_pc} !== {1'b1, mem_word(ep), ep}) begin
            fails++; $display("FAIL stall_ifid j%0d: got %b/%h/%h expected 1/%h/%h", j, id_valid, id_instr, id_pc, mem_word(ep), ep);
         end
`ifdef FETCH_PERF_CNT_EN
         if (j == 3) begin
            checks++; if ({perf_fetched, perf_stall_cycles} !== {32'd4, 32'd3}) begin
               fails++; $display("FAIL stall_perf: got %0d/%0d expected 4/3", perf_fetched, perf_stall_cycles);
            end
         end
`endif
      end
   endtask

   task automatic test_redirect;
      logic [31:0] a;
      @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
      checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL redir_req: got %b expected 0", imem_req); end
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk); redirect_valid = 1'b0; #1;
         a = 32'h200 + 4 * (j - 1);
         checks++; if ({imem_req, imem_addr} !== {1'b1, a}) begin
            fails++; $display("FAIL redir_addr t+%0d: got %b/%h expected 1/%h", j, imem_req, imem_addr, a);
         end
         checks++; if (id_valid !== (j >= 3)) begin
            fails++; $display("FAIL redir_valid t+%0d: got %b expected %0d", j, id_valid, j >= 3);
         end
         if (j >= 3) begin
            a = 32'h200 + 4 * (j - 3);
            checks++; if ({id_instr, id_pc} !== {mem_word(a), a}) begin
               fails++; $display("FAIL redir_ifid t+%0d: got %h/%h expected %h/%h", j, id_instr, id_pc, mem_word(a), a);
            end
         end
      end
   endtask

   task automatic test_redirect_in_hold;
      logic [31:0] a;
      @(negedge clk); stall = 1'b1; #1;
      checks++; if ({imem_req, id_valid, id_pc} !== {1'b0, 1'b1, 32'h208}) begin
         fails++; $display("FAIL hold_entry: got %b/%b/%h expected 0/1/00000208", imem_req, id_valid, id_pc);
      end
      @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h103; #1;
      checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL hold_redir_req: got %b expected 0", imem_req); end
      for (int j = 2; j <= 5; j++) begin
         @(negedge clk); stall = 1'b0; redirect_valid = 1'b0; #1;
         a = 32'h100 + 4 * (j - 2);
         checks++; if ({imem_req, imem_addr} !== {1'b1, a}) begin
            fails++; $display("FAIL hold_redir_addr c%0d: got %b/%h expected 1/%h", j, imem_req, imem_addr, a);
         end
         a = 32'h100 + 4 * (j - 4);
         checks++; if (j >= 4 ? ({id_valid, id_instr, id_pc} !== {1'b1, mem_word(a), a}) : ({id_valid, id_instr} !== {1'b0, NOP})) begin
            fails++; $display("FAIL hold_redir_ifid c%0d: got %b/%h/%h expected valid %0d pc %h", j, id_valid, id_instr, id_pc, j >= 4, a);
         end
      end
   endtask

   task automatic test_pc_wrap;
      logic [31:0] a;
      @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk); redirect_valid = 1'b0; #1;
         a = 32'hFFFF_FFFC + 4 * (j - 1);
         checks++; if ({imem_req, imem_addr} !== {1'b1, a}) begin
            fails++; $display("FAIL wrap_addr t+%0d: got %b/%h expected 1/%h", j, imem_req, imem_addr, a);
         end
         if (j >= 3) begin
            a = 32'hFFFF_FFFC + 4 * (j - 3);
            checks++; if ({id_valid, id_instr, id_pc} !== {1'b1, mem_word(a), a}) begin
               fails++; $display("FAIL wrap_ifid t+%0d: got %b/%h/%h expected 1/%h/%h", j, id_valid, id_instr, id_pc, mem_word(a), a);
            end
         end
      end
   endtask

   task automatic test_reset_mid_hold;
      @(negedge clk); stall = 1'b1; #1;
      @(negedge clk); stall = 1'b0; rst = 1'b1; #1;
      checks++; if ({imem_req, imem_addr} !== {1'b0, 32'h0}) begin
         fails++; $display("FAIL midrst_req: got %b/%h expected 0/00000000", imem_req, imem_addr);
      end
      checks++; if ({id_valid, id_instr, id_pc} !== {1'b0, NOP, 32'h0}) begin
         fails++; $display("FAIL midrst_ifid: got %b/%h/%h expected 0/%h/0", id_valid, id_instr, id_pc, NOP);
      end
`ifdef FETCH_PERF_CNT_EN
      checks++; if ({perf_fetched, perf_stall_cycles} !== 64'h0) begin
         fails++; $display("FAIL midrst_perf: got %h/%h expected 0/0", perf_fetched, perf_stall_cycles);
      end
`endif
      @(negedge clk); rst = 1'b0; #1;
      checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL restart_idle: got %b expected 0", imem_req); end
      @(negedge clk); #1;
      checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
         fails++; $display("FAIL restart_addr: got %b/%h expected 1/00000000", imem_req, imem_addr);
      end
      @(negedge clk); #1;
      checks++; if ({id_valid, id_instr} !== {1'b0, NOP}) begin
         fails++; $display("FAIL restart_bubble: got %b/%h expected 0/%h", id_valid, id_instr, NOP);
      end
      @(negedge clk); #1;
      checks++; if ({id_valid, id_instr, id_pc} !== {1'b1, mem_word(32'h0), 32'h0}) begin
         fails++; $display("FAIL restart_ifid: got %b/%h/%h expected 1/%h/0", id_valid, id_instr, id_pc, mem_word(32'h0));
      end
   endtask

   initial begin
      test_reset;
      test_basic_fetch;
      test_stall;
      test_redirect;
      test_redirect_in_hold;
      test_pc_wrap;
      test_reset_mid_hold;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage pipelined RV32I CPU. Generates the PC, issues requests to the synchronous instruction memory, and presents the fetched instruction, its PC and a validity bit to decode. Its outputs drive the load-use stall generator's validity input, and it consumes that block's `stall` output. A one-entry skid buffer absorbs the memory response that is in flight when a stall arrives, so no fetch is lost or repeated.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0013 (addi x0,x0,0): value driven on `id_instr` when the slot is invalid.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `stall` in 1: from the load-use stall generator; holds the IF/ID register.
- `redirect_valid` in 1: single-cycle taken branch/jump from EX.
- `redirect_pc` in 32: target address; bits [1:0] are ignored and treated as 0.
- `imem_req` out 1: fetch request this cycle.
- `imem_addr` out 32: word-aligned fetch address; valid while `imem_req`=1.
- `imem_rdata` in 32: instruction; valid exactly one cycle after `imem_req`=1.
- `id_instr` out 32: IF/ID instruction.
- `id_pc` out 32: IF/ID PC.
- `id_valid` out 1: IF/ID slot holds a real instruction.

## Operation
- Registers:
  - `pc`: next address to request.
  - `inflight`: `imem_req` was 1 in the previous cycle.
  - Skid: `skid_instr`, `skid_pc`.
  - `inflight_pc`.
  - FSM state.
- FSM states:
  - IDLE: entered on reset; `imem_req`=0; always goes to RUN next cycle.
  - RUN: skid empty.
  - HOLD: skid occupied.
- RUN, no redirect:
  - `imem_req` = !stall.
  - On an issued request, `pc` becomes `pc`+4, modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
  - `inflight` && !stall: IF/ID loads {`imem_rdata`, `inflight_pc`, valid=1}.
  - `inflight` && stall: the response is captured into the skid and the FSM moves to HOLD. IF/ID holds.
  - !`inflight` && !stall: IF/ID loads valid=0 and `NOP_INSTR`.
  - !`inflight` && stall: IF/ID holds.
- HOLD, no redirect:
  - stall=1: `imem_req`=0; IF/ID and skid hold.
  - stall=0: IF/ID loads the skid with valid=1. `imem_req`=1 at `pc` in the same cycle. The FSM returns to RUN.
- Redirect (`redirect_valid`=1, in any state): this has priority over stall and over any response.
  - `imem_req`=0 in the redirect cycle.
  - The response arriving in that cycle is discarded.
  - The skid is emptied.
  - IF/ID loads valid=0 / `NOP_INSTR`.
  - `pc` is loaded with {`redirect_pc`[31:2], 2'b00}.
  - The FSM goes to RUN.
- `id_pc` is don't-care while `id_valid`=0, but is driven deterministically (hold previous value).

## Timing
- Reset values, applied asynchronously:
  - `pc`=`RESET_PC`, FSM=IDLE, `inflight`=0, skid empty.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `id_valid`=0, `id_instr`=`NOP_INSTR`, `id_pc`=0.
- Sequence after `rst` deasserts:
  - Cycle 0 is IDLE.
  - Cycle 1 requests `RESET_PC`.
  - `id_valid`=1 with that instruction from cycle 3.
- Fetch-to-decode latency is 2 edges. Throughput without stalls is 1 instruction per cycle.
- Redirect at cycle t: request of the target at t+1; target instruction in IF/ID at t+3.
- Stall released at cycle t from HOLD: skid instruction in IF/ID at t+1, next instruction at t+2. No bubble.
- Reset asserted mid-operation discards the in-flight response and the skid contents immediately.
- `imem_req` and `imem_addr` are combinational from registered state plus `stall`/`redirect_valid`. There is no combinational path from `imem_rdata` to any output.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds two ports.
  - `perf_fetched` out 32: increments on each valid IF/ID load.
  - `perf_stall_cycles` out 32: increments each cycle where `stall` && `id_valid`.
  - Both counters reset to 0 and wrap modulo 2^32.
- Undefined: both ports and both counters are absent; all other behaviour is identical.

## Structure
- `cpu_pkg` holds:
  - `NOP_INSTR`, `RESET_PC` default.
  - The opcode localparams shared with decode and hazard logic.
  - Fetch FSM state enum `fetch_state_t` (IDLE, RUN, HOLD).
- One sub-module, `fetch_skid_buffer`: a one-entry {instr, pc} buffer with load/clear/full. FSM, PC and IF/ID register stay in `fetch_stage`.

## Test plan
- Reset release with `RESET_PC`=0, memory returns the address as data, no stall:
  - `imem_addr` is 0, 4, 8… on consecutive cycles.
  - `id_instr`/`id_pc` = 0/0, 4/4, 8/8 from cycle 3.
- Stall for 3 cycles starting while the request for 0x10 is in flight:
  - IF/ID holds 0x0C for 4 cycles in total.
  - `imem_req`=0 during the stall.
  - 0x10 comes from the skid on release, then 0x14 on the next cycle. No duplicate, no gap.
- Redirect to 0x200 while in RUN:
  - `id_valid`=0 for 2 cycles.
  - `imem_addr`=0x200 at t+1.
  - `id_pc`=0x200 at t+3.
- Redirect with `redirect_pc`=0x103 and `stall`=1 simultaneously, in HOLD:
  - Skid is flushed and `pc`=0x100.
  - Next fetch is 0x100; the stalled instruction never reappears.
- PC wrap: redirect to 0xFFFF_FFFC, then run:
  - Fetched addresses are 0xFFFF_FFFC, 0x0000_0000.
- Assert `rst` for 1 cycle mid-HOLD:
  - All outputs return to reset values at once.
  - Skid content is lost.
  - Fetch restarts at `RESET_PC`.
  - With `FETCH_PERF_CNT_EN`, counters read 0.
